// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM states, data widths and stream bundles.
package apb_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
    } apb_rsp_t;

    // Reads never assert byte strobes.
    function automatic logic [APB_STRB_WIDTH-1:0] apb_strb(input apb_cmd_t c);
        return c.write ? c.strb : '0;
    endfunction

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: command stream in, APB phases out,
// completion (rdata, slverr, wait count) returned on a response stream.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int WAIT_WIDTH = 8
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [APB_STRB_WIDTH-1:0] cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_slverr,
    output logic [WAIT_WIDTH-1:0]     rsp_waits,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic [APB_STRB_WIDTH-1:0] PSTRB,
    input  logic                      PREADY,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PSLVERR
);

    apb_state_t state;
    apb_cmd_t   cmd;
    apb_rsp_t   rsp;
    logic       take;

    always_comb begin
        cmd       = '0;
        cmd.write = cmd_write;
        cmd.wdata = cmd_wdata;
        cmd.strb  = cmd_strb;
    end

    // Gated by reset so every output reads 0 while PRESETn is low.
    assign cmd_ready = PRESETn &&
                       (state == IDLE || (state == RESP && rsp_ready));
    assign take = cmd_valid && cmd_ready;

    assign rsp_rdata  = rsp.rdata;
    assign rsp_slverr = rsp.slverr;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp       <= '0;
            rsp_waits <= '0;
        end else if (take) begin
            state     <= SETUP;
            PADDR     <= cmd_addr;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= cmd.write;
            PSTRB     <= apb_strb(cmd);
            rsp_valid <= 1'b0;
            rsp_waits <= '0;
            // Reads leave PWDATA untouched to avoid needless toggling.
            if (cmd.write) begin
                PWDATA <= cmd.wdata;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp.rdata  <= PWRITE ? '0 : PRDATA;
                        rsp.slverr <= PSLVERR;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (rsp_waits != '1) begin
                        rsp_waits <= rsp_waits + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: latency, wait states, errors,
// back-to-back streaming, backpressure and mid-transfer reset.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [0:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic [7:0]  rsp_waits;
    logic [0:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int n_tests;
    int n_fail;

    apb_master dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_waits  (rsp_waits),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic put_cmd(input logic w, input logic [0:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".PSEL"},       32'(PSEL),       32'h0);
        chk({tag, ".PENABLE"},    32'(PENABLE),    32'h0);
        chk({tag, ".PADDR"},      32'(PADDR),      32'h0);
        chk({tag, ".PWRITE"},     32'(PWRITE),     32'h0);
        chk({tag, ".PWDATA"},     PWDATA,          32'h0);
        chk({tag, ".PSTRB"},      32'(PSTRB),      32'h0);
        chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'h0);
        chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'h0);
        chk({tag, ".rsp_rdata"},  rsp_rdata,       32'h0);
        chk({tag, ".rsp_slverr"}, 32'(rsp_slverr), 32'h0);
        chk({tag, ".rsp_waits"},  32'(rsp_waits),  32'h0);
    endtask

    logic [31:0] b2b_data [4];
    int          done_cnt;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        b2b_data[0] = 32'h1111_0001;
        b2b_data[1] = 32'h2222_0002;
        b2b_data[2] = 32'h3333_0003;
        b2b_data[3] = 32'h4444_0004;

        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        chk("idle.cmd_ready", 32'(cmd_ready), 32'h1);
        chk("idle.PSEL", 32'(PSEL), 32'h0);

        // Zero-wait write
        put_cmd(1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("w0.setup.PSEL", 32'(PSEL), 32'h1);
        chk("w0.setup.PENABLE", 32'(PENABLE), 32'h0);
        chk("w0.PADDR", 32'(PADDR), 32'h1);
        chk("w0.PWRITE", 32'(PWRITE), 32'h1);
        chk("w0.PWDATA", PWDATA, 32'hDEAD_BEEF);
        chk("w0.PSTRB", 32'(PSTRB), 32'hF);
        chk("w0.setup.cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        chk("w0.access.PSEL", 32'(PSEL), 32'h1);
        chk("w0.access.PENABLE", 32'(PENABLE), 32'h1);
        chk("w0.access.PWDATA", PWDATA, 32'hDEAD_BEEF);
        chk("w0.access.rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("w0.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("w0.resp.PSEL", 32'(PSEL), 32'h0);
        chk("w0.resp.PENABLE", 32'(PENABLE), 32'h0);
        chk("w0.rdata", rsp_rdata, 32'h0);
        chk("w0.slverr", 32'(rsp_slverr), 32'h0);
        chk("w0.waits", 32'(rsp_waits), 32'h0);
        chk("w0.resp.cmd_ready", 32'(cmd_ready), 32'h0);
        rsp_ready = 1'b1;
        #1;
        chk("w0.resp.cmd_ready_rr", 32'(cmd_ready), 32'h1);
        tick();
        rsp_ready = 1'b0;
        chk("w0.idle.rsp_valid", 32'(rsp_valid), 32'h0);

        // Read with 3 wait states; PSLVERR during waits must be ignored
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'hAAAA_AAAA;
        put_cmd(1'b0, 1'b0, 32'h5555_5555, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("r3.PWRITE", 32'(PWRITE), 32'h0);
        chk("r3.setup.PSTRB", 32'(PSTRB), 32'h0);
        chk("r3.PWDATA_held", PWDATA, 32'hDEAD_BEEF);
        chk("r3.PADDR", 32'(PADDR), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("r3.wait%0d.PENABLE", i), 32'(PENABLE), 32'h1);
            chk($sformatf("r3.wait%0d.PSTRB", i), 32'(PSTRB), 32'h0);
            chk($sformatf("r3.wait%0d.rsp_valid", i), 32'(rsp_valid), 32'h0);
            tick();
        end
        chk("r3.last.PSEL", 32'(PSEL), 32'h1);
        chk("r3.last.rsp_valid", 32'(rsp_valid), 32'h0);
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h1234_5678;
        tick();
        chk("r3.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("r3.rdata", rsp_rdata, 32'h1234_5678);
        chk("r3.waits", 32'(rsp_waits), 32'h3);
        chk("r3.slverr", 32'(rsp_slverr), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Slave error on a write; rdata cleared by the write completion
        PSLVERR = 1'b1;
        put_cmd(1'b1, 1'b0, 32'hCAFE_0001, 4'h3);
        tick();
        cmd_valid = 1'b0;
        chk("err.PSTRB", 32'(PSTRB), 32'h3);
        tick();
        tick();
        chk("err.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("err.slverr", 32'(rsp_slverr), 32'h1);
        chk("err.rdata", rsp_rdata, 32'h0);
        chk("err.waits", 32'(rsp_waits), 32'h0);
        PSLVERR   = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Back-to-back: 4 writes, cmd_valid held, rsp_ready high
        done_cnt = 0;
        put_cmd(1'b1, 1'b1, b2b_data[0], 4'hF);
        for (int c = 0; c < 12; c++) begin
            tick();
            case (c % 3)
                0: begin
                    chk($sformatf("b2b%0d.setup.PSEL", c), 32'(PSEL), 32'h1);
                    chk($sformatf("b2b%0d.setup.PEN", c), 32'(PENABLE), 32'h0);
                    chk($sformatf("b2b%0d.PWDATA", c), PWDATA, b2b_data[c/3]);
                end
                1: begin
                    chk($sformatf("b2b%0d.acc.PEN", c), 32'(PENABLE), 32'h1);
                end
                default: begin
                    chk($sformatf("b2b%0d.resp.PSEL", c), 32'(PSEL), 32'h0);
                    chk($sformatf("b2b%0d.rsp_valid", c), 32'(rsp_valid), 32'h1);
                    if (rsp_valid) done_cnt++;
                    if (c / 3 < 3) cmd_wdata = b2b_data[c/3 + 1];
                    else cmd_valid = 1'b0;
                end
            endcase
        end
        chk("b2b.done_cnt", 32'(done_cnt), 32'h4);
        tick();
        chk("b2b.idle.PSEL", 32'(PSEL), 32'h0);
        chk("b2b.idle.rsp_valid", 32'(rsp_valid), 32'h0);

        // Response backpressure for 5 cycles with a command waiting
        rsp_ready = 1'b0;
        PRDATA    = 32'h0BAD_F00D;
        put_cmd(1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        put_cmd(1'b1, 1'b0, 32'h7777_7777, 4'h1);
        tick();
        tick();
        PRDATA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.rsp_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d.rdata", i), rsp_rdata, 32'h0BAD_F00D);
            chk($sformatf("bp%0d.cmd_ready", i), 32'(cmd_ready), 32'h0);
            chk($sformatf("bp%0d.PSEL", i), 32'(PSEL), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("bp.next.PSEL", 32'(PSEL), 32'h1);
        chk("bp.next.PWDATA", PWDATA, 32'h7777_7777);
        chk("bp.next.rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        tick();
        tick();

        // Mid-transfer reset during ACCESS
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        put_cmd(1'b1, 1'b1, 32'h9999_9999, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mr.access.PENABLE", 32'(PENABLE), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_all_zero("mr");
        tick();
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        tick();
        chk("mr.after.cmd_ready", 32'(cmd_ready), 32'h1);
        chk("mr.after.rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        tick();
        chk("mr.later.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr.later.PSEL", 32'(PSEL), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB4 requester that turns a valid/ready command stream into APB setup/access phases.
- Returns the completion (read data, slave error, wait-state count) on a valid/ready response stream.
- Sits directly upstream of our APB slave peripherals and drives their PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB.
- Used as the stimulus front end for slave-side equivalence and integration benches.

Parameters:
ADDR_WIDTH, 1, width of cmd_addr and PADDR; default matches our single-bit-address slaves.
WAIT_WIDTH, 8, width of the saturating wait-state counter reported in rsp_waits.

Ports:
PCLK  in  1  clock; everything samples on the rising edge.
PRESETn  in  1  reset; asynchronous assert, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  block accepts a command this cycle.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  target address.
cmd_wdata  in  32  write data.
cmd_strb  in  4  write byte strobes.
rsp_valid  out  1  completion present.
rsp_ready  in  1  consumer takes the completion.
rsp_rdata  out  32  read data; 0 for writes.
rsp_slverr  out  1  PSLVERR sampled at completion.
rsp_waits  out  WAIT_WIDTH  ACCESS cycles with PREADY=0, saturating.
PADDR  out  ADDR_WIDTH  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  32  APB write data.
PSTRB  out  4  APB strobes.
PREADY  in  1  slave ready.
PRDATA  in  32  slave read data.
PSLVERR  in  1  slave error.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is PRESETn, asynchronous and active-low.
- Reset values: all outputs are 0 while PRESETn=0 (PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_waits). State = IDLE.
- All outputs are registered, except cmd_ready, which is decoded from state and rsp_ready.
- State machine: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. cmd_valid=1 -> capture command into APB outputs, go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> capture response, drop PSEL/PENABLE, go to RESP. PREADY=0 -> stay in ACCESS and increment the wait counter, saturating at all-ones.
  - RESP: rsp_valid=1, response fields stable. rsp_ready=1 with cmd_valid=1 -> accept new command and go to SETUP (back-to-back). rsp_ready=1 with cmd_valid=0 -> go to IDLE. rsp_ready=0 -> hold.
- cmd_ready = (state==IDLE) or (state==RESP and rsp_ready).
- Latency: command handshake at cycle N -> SETUP at N+1 -> ACCESS at N+2 -> rsp_valid at N+3 with zero wait states. Each wait state adds one cycle.
- Minimum back-to-back spacing is 3 cycles per transfer.
- PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the end of ACCESS.
- Outside a transfer these outputs hold their last value; they are not zeroed, to save toggling.
- Reads drive PSTRB=4'h0 regardless of cmd_strb. Reads drive PWDATA with the last value (don't-care to the slave).
- rsp_rdata captures PRDATA only on a read completing. A write completion sets rsp_rdata=0.
- rsp_slverr captures PSLVERR only in the cycle where PREADY=1 in ACCESS.
- The wait counter clears when a new command is accepted.
- No timeout. A slave that never asserts PREADY holds the block in ACCESS indefinitely. That is by design, per APB (no abort).
- Reset during any state: immediate return to IDLE with reset values. An in-flight command is dropped with no response.

Decomposition:
- Shared package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP); constants APB_DATA_WIDTH=32 and APB_STRB_WIDTH=4; packed structs apb_cmd_t and apb_rsp_t for the command and response streams.
- Single module; no sub-module. The saturating counter is inline.

Test Plan:
- Zero-wait write: cmd write addr=1, wdata=32'hDEADBEEF, strb=4'hF, PREADY tied 1 -> PSEL high 2 cycles, PENABLE high 1 cycle, rsp_valid at N+3 with rdata=0, slverr=0, waits=0.
- Read with 3 wait states: PREADY=0 for 3 ACCESS cycles, PRDATA=32'h12345678 on completion -> PSTRB=0 throughout, rsp_rdata=32'h12345678, rsp_waits=3, rsp_valid at N+6.
- Slave error: PSLVERR=1 with PREADY=1 on a write -> rsp_slverr=1. PSLVERR=1 while PREADY=0 is ignored.
- Back-to-back with rsp_ready=1 and cmd_valid held: 4 writes -> transfers complete every 3 cycles; PSEL returns low for exactly 1 cycle between transfers.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and response fields held, cmd_ready=0, no new SETUP.
- Mid-transfer reset: PRESETn low during ACCESS -> all outputs 0 asynchronously; after release, IDLE with cmd_ready=1 and no stale rsp_valid.
